// File: rtl/wb_mem_arbiter_pkg.sv
// Shared definitions for the two-master Wishbone memory arbiter.
package wb_mem_arbiter_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned SEL_W  = 4;

  // Master index constants, also the encoding held in last_grant.
  localparam logic M0 = 1'b0;
  localparam logic M1 = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_GRANT0,
    ST_GRANT1,
    ST_DRAIN
  } arb_state_t;

endpackage

// File: rtl/wb_mem_arbiter_watchdog.sv
// Per-grant watchdog: counts unacknowledged granted cycles and flags the
// cycle on which the limit is reached.
module wb_watchdog
  import wb_mem_arbiter_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_timeout
);

  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] count;

  // Count enabled cycles; clear wins over enable.
  always_ff @(posedge i_clk) begin
    if (i_rst || i_clr) begin
      count <= '0;
    end else if (i_en) begin
      count <= count + CW'(1);
    end
  end

  assign o_timeout = i_en && (count == LAST);

endmodule

// File: rtl/wb_mem_arbiter.sv
// Two-master to one-slave Wishbone arbiter: round-robin, bus locked for
// the whole CYC, watchdog-terminated hung transfers.
module wb_mem_arbiter
  import wb_mem_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = 10,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_m0_cyc,
  input  logic                  i_m0_stb,
  input  logic                  i_m0_we,
  input  logic [ADDR_WIDTH-1:0] i_m0_addr,
  input  logic [DATA_W-1:0]     i_m0_data,
  input  logic [SEL_W-1:0]      i_m0_sel,
  output logic                  o_m0_ack,
  output logic                  o_m0_err,
  output logic                  o_m0_stall,
  output logic [DATA_W-1:0]     o_m0_data,
  input  logic                  i_m1_cyc,
  input  logic                  i_m1_stb,
  input  logic                  i_m1_we,
  input  logic [ADDR_WIDTH-1:0] i_m1_addr,
  input  logic [DATA_W-1:0]     i_m1_data,
  input  logic [SEL_W-1:0]      i_m1_sel,
  output logic                  o_m1_ack,
  output logic                  o_m1_err,
  output logic                  o_m1_stall,
  output logic [DATA_W-1:0]     o_m1_data,
  output logic                  o_s_cyc,
  output logic                  o_s_stb,
  output logic                  o_s_we,
  output logic [ADDR_WIDTH-1:0] o_s_addr,
  output logic [DATA_W-1:0]     o_s_data,
  output logic [SEL_W-1:0]      o_s_sel,
  input  logic                  i_s_ack,
  input  logic                  i_s_stall,
  input  logic [DATA_W-1:0]     i_s_data
);

  arb_state_t state;
  logic       last_grant;
  logic       err_q;
  logic       pending;
  logic       granted;
  logic       own_cyc;
  logic       own_stb;
  logic       wd_clr;
  logic       wd_en;
  logic       wd_timeout;

  // last_grant is updated on every grant, so it also names the current
  // owner throughout GRANTx and DRAIN.
  assign granted = (state == ST_GRANT0) || (state == ST_GRANT1);
  assign own_cyc = (last_grant == M1) ? i_m1_cyc : i_m0_cyc;
  assign own_stb = (last_grant == M1) ? i_m1_stb : i_m0_stb;

  assign wd_clr = !granted || i_s_ack;
  assign wd_en  = granted && (own_stb || pending) && !i_s_ack;

  wb_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_clr     (wd_clr),
    .i_en      (wd_en),
    .o_timeout (wd_timeout)
  );

  // Arbitration state machine with round-robin tie break and lock until CYC drops.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state      <= ST_IDLE;
      last_grant <= M1;
      err_q      <= 1'b0;
      pending    <= 1'b0;
    end else begin
      err_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          pending <= 1'b0;
          if (i_m0_cyc && (!i_m1_cyc || last_grant == M1)) begin
            state      <= ST_GRANT0;
            last_grant <= M0;
          end else if (i_m1_cyc) begin
            state      <= ST_GRANT1;
            last_grant <= M1;
          end
        end
        ST_GRANT0, ST_GRANT1: begin
          pending <= (pending || (own_stb && !i_s_stall)) && !i_s_ack;
          if (!own_cyc) begin
            state <= ST_IDLE;
          end else if (wd_timeout) begin
            state <= ST_DRAIN;
            err_q <= 1'b1;
          end
        end
        ST_DRAIN: begin
          if (!own_cyc) begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Bus mux driven from the state register; reset blanks it immediately so
  // an aborted transfer never sees an ack.
  always_comb begin
    o_s_cyc    = 1'b0;
    o_s_stb    = 1'b0;
    o_s_we     = 1'b0;
    o_s_addr   = '0;
    o_s_data   = '0;
    o_s_sel    = '0;
    o_m0_ack   = 1'b0;
    o_m0_err   = 1'b0;
    o_m0_stall = 1'b1;
    o_m0_data  = '0;
    o_m1_ack   = 1'b0;
    o_m1_err   = 1'b0;
    o_m1_stall = 1'b1;
    o_m1_data  = '0;
    if (!i_rst) begin
      case (state)
        ST_GRANT0: begin
          o_s_cyc    = i_m0_cyc;
          o_s_stb    = i_m0_stb;
          o_s_we     = i_m0_we;
          o_s_addr   = i_m0_addr;
          o_s_data   = i_m0_data;
          o_s_sel    = i_m0_sel;
          o_m0_ack   = i_s_ack;
          o_m0_stall = i_s_stall;
          o_m0_data  = i_s_data;
        end
        ST_GRANT1: begin
          o_s_cyc    = i_m1_cyc;
          o_s_stb    = i_m1_stb;
          o_s_we     = i_m1_we;
          o_s_addr   = i_m1_addr;
          o_s_data   = i_m1_data;
          o_s_sel    = i_m1_sel;
          o_m1_ack   = i_s_ack;
          o_m1_stall = i_s_stall;
          o_m1_data  = i_s_data;
        end
        ST_DRAIN: begin
          o_m0_err = err_q && (last_grant == M0);
          o_m1_err = err_q && (last_grant == M1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_mem_arbiter.sv
// Directed bench for wb_mem_arbiter with a small expected-value queue.
module tb_wb_mem_arbiter;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        i_m0_cyc, i_m0_stb, i_m0_we;
  logic [9:0]  i_m0_addr;
  logic [31:0] i_m0_data;
  logic [3:0]  i_m0_sel;
  logic        o_m0_ack, o_m0_err, o_m0_stall;
  logic [31:0] o_m0_data;
  logic        i_m1_cyc, i_m1_stb, i_m1_we;
  logic [9:0]  i_m1_addr;
  logic [31:0] i_m1_data;
  logic [3:0]  i_m1_sel;
  logic        o_m1_ack, o_m1_err, o_m1_stall;
  logic [31:0] o_m1_data;
  logic        o_s_cyc, o_s_stb, o_s_we;
  logic [9:0]  o_s_addr;
  logic [31:0] o_s_data;
  logic [3:0]  o_s_sel;
  logic        i_s_ack, i_s_stall;
  logic [31:0] i_s_data;

  int unsigned errors = 0;
  int unsigned checks = 0;
  logic [31:0] sb_q[$];

  always #5 i_clk = ~i_clk;

  wb_mem_arbiter #(
    .ADDR_WIDTH(10),
    .TIMEOUT_CYCLES(4)
  ) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_m0_cyc(i_m0_cyc), .i_m0_stb(i_m0_stb), .i_m0_we(i_m0_we),
    .i_m0_addr(i_m0_addr), .i_m0_data(i_m0_data), .i_m0_sel(i_m0_sel),
    .o_m0_ack(o_m0_ack), .o_m0_err(o_m0_err), .o_m0_stall(o_m0_stall),
    .o_m0_data(o_m0_data),
    .i_m1_cyc(i_m1_cyc), .i_m1_stb(i_m1_stb), .i_m1_we(i_m1_we),
    .i_m1_addr(i_m1_addr), .i_m1_data(i_m1_data), .i_m1_sel(i_m1_sel),
    .o_m1_ack(o_m1_ack), .o_m1_err(o_m1_err), .o_m1_stall(o_m1_stall),
    .o_m1_data(o_m1_data),
    .o_s_cyc(o_s_cyc), .o_s_stb(o_s_stb), .o_s_we(o_s_we),
    .o_s_addr(o_s_addr), .o_s_data(o_s_data), .o_s_sel(o_s_sel),
    .i_s_ack(i_s_ack), .i_s_stall(i_s_stall), .i_s_data(i_s_data)
  );

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_sb(input string tag, input logic [31:0] obs);
    logic [31:0] exp;
    if (sb_q.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL %s: observed %h expected <empty scoreboard>", tag, obs);
    end else begin
      exp = sb_q.pop_front();
      chk(tag, obs, exp);
    end
  endtask

  // One tie round: both raise CYC in IDLE; winner identified by its stall.
  task automatic tie_round(input logic exp_m1);
    i_m0_cyc = 1'b1;
    i_m1_cyc = 1'b1;
    sb_q.push_back(32'(exp_m1));
    tick(); settle();
    chk_sb("tie_winner", 32'(o_m0_stall));
    chk("tie_exclusive", 32'(o_m0_stall ^ o_m1_stall), 1);
    i_m0_cyc = 1'b0;
    i_m1_cyc = 1'b0;
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: observed running expected finished");
    $fatal(1, "simulation time limit");
  end

  initial begin
    i_rst = 1'b1;
    i_m0_cyc = 0; i_m0_stb = 0; i_m0_we = 0; i_m0_addr = '0; i_m0_data = '0; i_m0_sel = '0;
    i_m1_cyc = 0; i_m1_stb = 0; i_m1_we = 0; i_m1_addr = '0; i_m1_data = '0; i_m1_sel = '0;
    i_s_ack = 0; i_s_stall = 0; i_s_data = '0;
    tick(); tick();
    i_rst = 1'b0;
    settle();

    // Reset / IDLE output values.
    chk("rst_s_cyc", 32'(o_s_cyc), 0);
    chk("rst_s_addr", 32'(o_s_addr), 0);
    chk("rst_m0_stall", 32'(o_m0_stall), 1);
    chk("rst_m1_stall", 32'(o_m1_stall), 1);
    chk("rst_m0_data", o_m0_data, 0);

    // Round-robin ties: M0, then M1, then M0.
    tie_round(1'b0);
    tie_round(1'b1);
    tie_round(1'b0);

    // Single M0 read with ACK one cycle after strobe.
    i_m0_cyc = 1; i_m0_stb = 1; i_m0_addr = 10'h010; i_m0_sel = 4'hF;
    sb_q.push_back(32'h0000_0013);
    settle();
    chk("rd_latency_stb", 32'(o_s_stb), 0);
    tick(); settle();
    chk("rd_s_stb", 32'(o_s_stb), 1);
    chk("rd_s_addr", 32'(o_s_addr), 32'h010);
    chk("rd_m0_ack_early", 32'(o_m0_ack), 0);
    chk("rd_m1_stall_c1", 32'(o_m1_stall), 1);
    tick();
    i_s_ack = 1; i_s_data = 32'h0000_0013;
    settle();
    chk("rd_m0_ack", 32'(o_m0_ack), 1);
    chk_sb("rd_m0_data", o_m0_data);
    chk("rd_m1_stall_c2", 32'(o_m1_stall), 1);
    chk("rd_m1_data", o_m1_data, 0);
    tick();
    i_s_ack = 0; i_s_data = '0; i_m0_cyc = 0; i_m0_stb = 0;
    settle();
    chk("rd_drop_same_cycle", 32'(o_s_cyc), 0);
    tick(); settle();
    chk("rd_idle_m0_stall", 32'(o_m0_stall), 1);

    // Lock: M1 write, M0 requests mid-cycle and waits.
    i_m1_cyc = 1; i_m1_stb = 1; i_m1_we = 1; i_m1_sel = 4'b0011;
    i_m1_data = 32'hDEAD_BEEF; i_m1_addr = 10'h020;
    tick(); settle();
    chk("lk_s_sel", 32'(o_s_sel), 32'h3);
    chk("lk_s_we", 32'(o_s_we), 1);
    chk("lk_s_data", o_s_data, 32'hDEAD_BEEF);
    i_m0_cyc = 1; i_m0_stb = 1; i_m0_addr = 10'h030; i_m0_sel = 4'hF;
    tick();
    i_s_ack = 1;
    settle();
    chk("lk_m1_ack", 32'(o_m1_ack), 1);
    chk("lk_m0_ack", 32'(o_m0_ack), 0);
    chk("lk_m0_stall_ack", 32'(o_m0_stall), 1);
    tick();
    i_s_ack = 0; i_m1_stb = 0;
    for (int i = 0; i < 5; i++) begin
      settle();
      chk("lk_m0_stall_hold", 32'(o_m0_stall), 1);
      chk("lk_s_addr_hold", 32'(o_s_addr), 32'h020);
      tick();
    end
    i_m1_cyc = 0; i_m1_we = 0; i_m1_sel = '0;
    settle();
    chk("lk_release_s_cyc", 32'(o_s_cyc), 0);
    tick(); settle();
    chk("lk_idle_s_cyc", 32'(o_s_cyc), 0);
    chk("lk_idle_m0_stall", 32'(o_m0_stall), 1);
    chk("lk_idle_s_sel", 32'(o_s_sel), 0);
    tick();
    i_s_ack = 1; i_s_data = 32'h0000_0055;
    sb_q.push_back(32'h0000_0055);
    settle();
    chk("lk_g0_s_addr", 32'(o_s_addr), 32'h030);
    chk("lk_g0_s_sel", 32'(o_s_sel), 32'hF);
    chk("lk_g0_ack", 32'(o_m0_ack), 1);
    chk_sb("lk_g0_data", o_m0_data);
    tick();
    i_s_ack = 0; i_s_data = '0; i_m0_cyc = 0; i_m0_stb = 0;
    tick();

    // Timeout: slave never ACKs M1; error one cycle after the 4th stalled cycle.
    i_m1_cyc = 1; i_m1_stb = 1; i_m1_addr = 10'h040; i_s_stall = 1;
    tick();
    i_m0_cyc = 1;
    for (int i = 0; i < 4; i++) begin
      settle();
      chk("to_no_err_yet", 32'(o_m1_err), 0);
      chk("to_s_cyc_held", 32'(o_s_cyc), 1);
      tick();
    end
    settle();
    chk("to_err_pulse", 32'(o_m1_err), 1);
    chk("to_s_cyc_forced", 32'(o_s_cyc), 0);
    chk("to_m1_stall", 32'(o_m1_stall), 1);
    chk("to_m0_err", 32'(o_m0_err), 0);
    for (int i = 0; i < 3; i++) begin
      tick(); settle();
      chk("to_err_once", 32'(o_m1_err), 0);
      chk("to_drain_s_cyc", 32'(o_s_cyc), 0);
      chk("to_drain_m0_stall", 32'(o_m0_stall), 1);
    end
    i_m1_cyc = 0; i_m1_stb = 0; i_s_stall = 0;
    tick(); settle();
    chk("to_idle_m0_stall", 32'(o_m0_stall), 1);
    chk("to_idle_s_cyc", 32'(o_s_cyc), 0);
    tick(); settle();
    chk("to_g0_s_cyc", 32'(o_s_cyc), 1);
    chk("to_g0_m0_stall", 32'(o_m0_stall), 0);
    i_m0_cyc = 0;
    tick();

    // ACK on the last allowed cycle: ACK wins, no error.
    i_m0_cyc = 1; i_m0_stb = 1; i_m0_addr = 10'h044; i_s_stall = 1;
    for (int i = 0; i < 3; i++) begin
      tick(); settle();
      chk("af_no_err", 32'(o_m0_err), 0);
    end
    tick();
    i_s_stall = 0; i_s_ack = 1; i_s_data = 32'h0000_0077;
    sb_q.push_back(32'h0000_0077);
    settle();
    chk("af_ack", 32'(o_m0_ack), 1);
    chk_sb("af_data", o_m0_data);
    chk("af_err_ack_cycle", 32'(o_m0_err), 0);
    tick();
    i_s_ack = 0; i_s_data = '0;
    settle();
    chk("af_err_after", 32'(o_m0_err), 0);
    chk("af_still_granted", 32'(o_s_cyc), 1);
    i_m0_cyc = 0; i_m0_stb = 0;
    tick();

    // Reset mid-transfer in GRANT0, then the first tie goes to M0.
    i_m0_cyc = 1; i_m0_stb = 1; i_m0_addr = 10'h050;
    tick(); settle();
    chk("rm_granted_stb", 32'(o_s_stb), 1);
    i_rst = 1; i_m1_cyc = 1; i_s_ack = 1;
    tick();
    i_rst = 0; i_s_ack = 0;
    settle();
    chk("rm_s_cyc", 32'(o_s_cyc), 0);
    chk("rm_s_stb", 32'(o_s_stb), 0);
    chk("rm_s_addr", 32'(o_s_addr), 0);
    chk("rm_m0_stall", 32'(o_m0_stall), 1);
    chk("rm_m1_stall", 32'(o_m1_stall), 1);
    chk("rm_m0_ack", 32'(o_m0_ack), 0);
    chk("rm_m0_err", 32'(o_m0_err), 0);
    sb_q.push_back(32'd0);
    tick(); settle();
    chk_sb("rm_tie_winner", 32'(o_m0_stall));
    chk("rm_m1_locked_out", 32'(o_m1_stall), 1);
    i_m0_cyc = 0; i_m0_stb = 0; i_m1_cyc = 0;
    tick();

    if (sb_q.size() != 0) begin
      checks++;
      errors++;
      $error("FAIL sb_drain: observed %0d leftover entries expected 0", sb_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
